// File: rtl/cpu_stage_ctrl_pkg.sv
// Shared definitions for the multi-cycle stage sequencer: 3-bit state
// encoding, error codes, the "no LSU op" opcode value and the default
// ack/done wait limit.
package cpu_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_FETCH   = 2'b01,
    ERR_DECODE  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam int unsigned LSU_NOP         = 0;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cpu_stage_ctrl_if.sv
// Handshake/enable bundle between the stage sequencer and the
// IFU/IDU/EXU/LSU/regfile datapath.
//   master : sequencer side (drives o_* strobes/status, samples i_* decode/acks)
//   slave  : datapath side (mirror image)
interface cpu_stage_ctrl_if #(
  parameter int unsigned LSU_OPT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH     = 64
);
  logic                     o_ifu_req;
  logic                     i_ifu_ack;
  logic                     o_ir_wen;
  logic                     i_ebreak;
  logic [2:0]               i_id_err;
  logic                     i_exu_multi;
  logic                     o_exu_start;
  logic                     i_exu_done;
  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt;
  logic                     i_is_store;
  logic                     o_lsu_req;
  logic                     i_lsu_ack;
  logic                     i_rd_wen;
  logic                     o_rf_wen;
  logic                     o_pc_wen;
  logic                     o_halt;
  logic                     o_err;
  logic [1:0]               o_err_code;
  logic [CNT_WIDTH-1:0]     o_cycle_cnt;
  logic [CNT_WIDTH-1:0]     o_instret;
  logic [2:0]               o_state;

  modport master (
    output o_ifu_req, o_ir_wen, o_exu_start, o_lsu_req, o_rf_wen, o_pc_wen,
           o_halt, o_err, o_err_code, o_cycle_cnt, o_instret, o_state,
    input  i_ifu_ack, i_ebreak, i_id_err, i_exu_multi, i_exu_done,
           i_lsu_opt, i_is_store, i_lsu_ack, i_rd_wen
  );

  modport slave (
    input  o_ifu_req, o_ir_wen, o_exu_start, o_lsu_req, o_rf_wen, o_pc_wen,
           o_halt, o_err, o_err_code, o_cycle_cnt, o_instret, o_state,
    output i_ifu_ack, i_ebreak, i_id_err, i_exu_multi, i_exu_done,
           i_lsu_opt, i_is_store, i_lsu_ack, i_rd_wen
  );
endinterface

// File: rtl/cpu_stage_ctrl_wait_timer.sv
// Wait-cycle counter for the sequencer's blocking states.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : restart count (state change)
//   en_i          : currently waiting on an ack/done
//   done_i        : the awaited ack/done arrived this cycle
//   expired_o     : this is the TIMEOUT-th waiting cycle with no ack/done
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  input  logic done_i,
  output logic expired_o
);
  localparam int unsigned    W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of already-elapsed waiting cycles, so the
  // limit is hit while still in the last allowed cycle; an ack/done in
  // that same cycle suppresses expiry.
  assign expired_o = en_i & ~done_i & (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (en_i && !done_i && cnt_q != LIMIT)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle stage sequencer for the RV64 core: fetch, IR latch, decode
// check, multi-cycle EXU start, LSU access, writeback and PC update, one
// stage at a time. Stops on ebreak (HALT) or on decode error / timeout
// (ERR), and keeps cycle and retired-instruction counters.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : handshake/enable bundle (master side)
module cpu_stage_ctrl
  import cpu_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT       = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH     = 64,
  parameter int unsigned LSU_OPT_WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  cpu_stage_ctrl_if.master bus
);
  state_e               state_q, state_d;
  err_e                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cycle_q, instret_q;

  logic wait_en, wait_done, expired;
  logic ifu_req, ir_wen, exu_start, lsu_req, rf_wen, pc_wen, halt, err;

  ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clear_i  (state_d != state_q),
    .en_i     (wait_en),
    .done_i   (wait_done),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wait_en   = 1'b0;
    wait_done = 1'b0;
    ifu_req   = 1'b0;
    ir_wen    = 1'b0;
    exu_start = 1'b0;
    lsu_req   = 1'b0;
    rf_wen    = 1'b0;
    pc_wen    = 1'b0;
    halt      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        ifu_req   = 1'b1;
        ir_wen    = bus.i_ifu_ack;
        wait_en   = 1'b1;
        wait_done = bus.i_ifu_ack;
        if (bus.i_ifu_ack) state_d = ST_DECODE;
        else if (expired) begin
          state_d = ST_ERR;
          err_d   = ERR_FETCH;
        end
      end
      ST_DECODE: begin
        if (bus.i_ebreak) state_d = ST_HALT;
        else if (|bus.i_id_err) begin
          state_d = ST_ERR;
          err_d   = ERR_DECODE;
        end else if (bus.i_exu_multi) begin
          state_d   = ST_EXEC;
          exu_start = 1'b1;
        end else if (bus.i_lsu_opt != LSU_OPT_WIDTH'(LSU_NOP) || bus.i_is_store)
          state_d = ST_MEM;
        else
          state_d = ST_WB;
      end
      ST_EXEC: begin
        wait_en   = 1'b1;
        wait_done = bus.i_exu_done;
        if (bus.i_exu_done) state_d = ST_WB;
        else if (expired) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_MEM: begin
        lsu_req   = 1'b1;
        wait_en   = 1'b1;
        wait_done = bus.i_lsu_ack;
        if (bus.i_lsu_ack) state_d = ST_WB;
        else if (expired) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_WB: begin
        rf_wen  = bus.i_rd_wen;
        pc_wen  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halt = 1'b1;
      ST_ERR: begin
        halt = 1'b1;
        err  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
        cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (state_q == ST_WB)
        instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  // Requests and strobes are masked while reset is asserted so a reset
  // landing mid-access drops the request and suppresses any write that cycle.
  assign bus.o_ifu_req   = ifu_req   & i_rst_n;
  assign bus.o_ir_wen    = ir_wen    & i_rst_n;
  assign bus.o_exu_start = exu_start & i_rst_n;
  assign bus.o_lsu_req   = lsu_req   & i_rst_n;
  assign bus.o_rf_wen    = rf_wen    & i_rst_n;
  assign bus.o_pc_wen    = pc_wen    & i_rst_n;
  assign bus.o_halt      = halt;
  assign bus.o_err       = err;
  assign bus.o_err_code  = err_q;
  assign bus.o_cycle_cnt = cycle_q;
  assign bus.o_instret   = instret_q;
  assign bus.o_state     = state_q;
endmodule
